// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the branch-FSM state encoding, default widths, the control-pin
// payload struct and the counter saturation helper.
package pipe_ctrl_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] BR_EX  = 2'd1;
  localparam logic [1:0] BR_MEM = 2'd2;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_RUN    = RUN,
    S_BR_EX  = BR_EX,
    S_BR_MEM = BR_MEM
  } state_e;

  // Control pins toward the PC unit and the pipeline registers.
  typedef struct packed {
    logic pc_stall;
    logic pc_jump;
    logic pc_branch;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // All-ones value of a w-bit counter (w <= 64); 1<<64 wraps to 0 so w=64 works.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports: clk, rst (sync, active-high), inc (count this cycle),
//        cnt (current value, holds at all-ones).
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: load-use stalls,
// jump redirect from ID and branch resolution from MEM.
// Inputs : clk, rst (sync, active-high), ID operand fields/uses, ID branch/
//          jump, EX load + destination, MEM branch valid/taken.
// Outputs: pc_stall/pc_jump/pc_branch, ifid_stall/ifid_flush, idex_flush,
//          exmem_flush (same-cycle controls), stall_cnt/flush_cnt counters.
// Build option: PIPE_PREDICT_NT_EN selects predict-not-taken handling
// instead of freezing fetch until the branch resolves.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             ex_memR,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_br_valid,
  input  logic             mem_br_taken,
  output logic             pc_stall,
  output logic             pc_jump,
  output logic             pc_branch,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic  lu_c;
  ctrl_t ctrl_c;

  // Load in EX feeds a register that ID reads; r0 never creates a hazard.
  assign lu_c = ex_memR & (ex_dst != '0) &
                ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));

`ifdef PIPE_PREDICT_NT_EN
  // inflight bit0: branch now in EX, bit1: branch now in MEM.
  logic [1:0] inflight_q;
  logic [1:0] inflight_d;
  logic       taken_c;

  always_comb begin
    ctrl_c     = '0;
    inflight_d = inflight_q;
    taken_c    = mem_br_valid & mem_br_taken & inflight_q[1];
    if (taken_c) begin
      // Taken resolve wins over lu/jump and squashes every younger branch.
      ctrl_c.pc_branch   = 1'b1;
      ctrl_c.ifid_flush  = 1'b1;
      ctrl_c.idex_flush  = 1'b1;
      ctrl_c.exmem_flush = 1'b1;
      inflight_d         = '0;
    end else begin
      // A stalled ID branch is re-presented, so only track it when it advances.
      inflight_d = {inflight_q[0], id_branch & ~lu_c};
      if (lu_c) begin
        ctrl_c.pc_stall   = 1'b1;
        ctrl_c.ifid_stall = 1'b1;
        ctrl_c.idex_flush = 1'b1;
      end else if (id_jump) begin
        ctrl_c.pc_jump    = 1'b1;
        ctrl_c.ifid_flush = 1'b1;
      end
    end
    if (rst) begin
      ctrl_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end
`else
  state_e state_q;
  state_e state_d;

  // Next state and same-cycle controls; branches freeze fetch until MEM.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      S_RUN: begin
        if (lu_c) begin
          ctrl_c.pc_stall   = 1'b1;
          ctrl_c.ifid_stall = 1'b1;
          ctrl_c.idex_flush = 1'b1;
        end else if (id_jump) begin
          ctrl_c.pc_jump    = 1'b1;
          ctrl_c.ifid_flush = 1'b1;
        end else if (id_branch) begin
          ctrl_c.pc_stall   = 1'b1;
          ctrl_c.ifid_flush = 1'b1;
          state_d           = S_BR_EX;
        end
      end
      S_BR_EX: begin
        ctrl_c.pc_stall   = 1'b1;
        ctrl_c.ifid_flush = 1'b1;
        state_d           = S_BR_MEM;
      end
      S_BR_MEM: begin
        // Not taken: PC was held at branch+4, so simply resume.
        if (mem_br_valid & mem_br_taken) begin
          ctrl_c.pc_branch  = 1'b1;
          ctrl_c.ifid_flush = 1'b1;
        end
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (rst) begin
      ctrl_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  assign pc_stall    = ctrl_c.pc_stall;
  assign pc_jump     = ctrl_c.pc_jump;
  assign pc_branch   = ctrl_c.pc_branch;
  assign ifid_stall  = ctrl_c.ifid_stall;
  assign ifid_flush  = ctrl_c.ifid_flush;
  assign idex_flush  = ctrl_c.idex_flush;
  assign exmem_flush = ctrl_c.exmem_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_c.pc_stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ctrl_c.ifid_flush | ctrl_c.idex_flush | ctrl_c.exmem_flush),
    .cnt (flush_cnt)
  );

endmodule
